// File: rtl/pe_arr_pkg.sv
// pe_arr_pkg: shared widths, drain FSM states and requantization limits for the PE array drain.
package pe_arr_pkg;
   localparam int DEF_ACC_W = 32;
   localparam int DEF_Q_W   = 8;
   localparam int Q_MAX     = 127;
   localparam int Q_MIN     = -128;
   typedef enum logic {IDLE, SEND} drain_state_t;
endpackage

// File: rtl/pe_requant.sv
// pe_requant: rounds a signed accumulator right by shift (half up) and saturates to Q_W bits.
module pe_requant
   import pe_arr_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W,
   parameter int Q_W   = DEF_Q_W
) (
   input  logic [ACC_W-1:0] x,
   input  logic [4:0]       shift,
   output logic [Q_W-1:0]   q
);
   localparam logic signed [ACC_W:0] HI = (ACC_W+1)'(Q_MAX);
   localparam logic signed [ACC_W:0] LO = (ACC_W+1)'(Q_MIN);
   logic signed [ACC_W:0] ext, rnd, sum, y;
   // One extra bit keeps x + rounding constant from wrapping at the positive extreme.
   assign ext = {x[ACC_W-1], x};
   assign rnd = (shift == 5'd0) ? '0 : ((ACC_W+1)'(1) << (shift - 5'd1));
   assign sum = ext + rnd;
   assign y   = sum >>> shift;
   assign q   = (y > HI) ? Q_W'(Q_MAX) : (y < LO) ? Q_W'(Q_MIN) : y[Q_W-1:0];
endmodule

// File: rtl/pe_arr_drain.sv
// pe_arr_drain: snapshots a completed PE tile on the rising edge of all-valid, requantizes it,
// and streams it out one row per valid/ready beat.
module pe_arr_drain
   import pe_arr_pkg::*;
#(
   parameter int ROWS  = 8,
   parameter int COLS  = 8,
   parameter int ACC_W = DEF_ACC_W,
   parameter int Q_W   = DEF_Q_W
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [ACC_W-1:0]         outs [0:ROWS*COLS-1],
   input  logic                     outvalids [0:ROWS*COLS-1],
   input  logic [4:0]               shift,
   input  logic                     clr_ovr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [COLS*Q_W-1:0]      out_data,
   output logic [$clog2(ROWS)-1:0]  out_row,
   output logic                     out_last,
   output logic                     busy,
   output logic                     overrun
);
   localparam int N  = ROWS * COLS;
   localparam int RW = $clog2(ROWS);
   drain_state_t state, next_state;
   logic [RW-1:0] row_cnt;
   logic all_v, all_v_q, tile_evt, hs;
   logic [Q_W-1:0] q [N];
   logic [COLS*Q_W-1:0] tile_buf [ROWS];

   for (genvar g = 0; g < N; g++) begin : g_rq
      pe_requant #(.ACC_W(ACC_W), .Q_W(Q_W)) u_rq (.x(outs[g]), .shift(shift), .q(q[g]));
   end

   always_comb begin
      all_v = 1'b1;
      for (int i = 0; i < N; i++) all_v &= outvalids[i];
   end

   // Edge detect so a tile whose valids stay high is captured only once.
   assign tile_evt = all_v & ~all_v_q;

   always_comb begin
      out_valid  = (state == SEND);
      busy       = (state != IDLE);
      out_row    = row_cnt;
      out_last   = out_valid && (row_cnt == RW'(ROWS - 1));
      out_data   = out_valid ? tile_buf[row_cnt] : '0;
      hs         = out_valid & out_ready;
      next_state = (state == IDLE) ? (tile_evt ? SEND : IDLE) : ((hs && out_last) ? IDLE : SEND);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= IDLE;
         row_cnt <= '0;
         all_v_q <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= next_state;
         all_v_q <= all_v;
         if (state == IDLE) row_cnt <= '0;
         else if (hs) row_cnt <= out_last ? '0 : row_cnt + 1'b1;
         overrun <= (tile_evt && state == SEND) | (overrun & ~clr_ovr);
      end
   end

   always_ff @(posedge clk) begin
      if (rstn && state == IDLE && tile_evt)
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               tile_buf[r][c*Q_W +: Q_W] <= q[r*COLS + c];
   end
endmodule

// File: doc/pe_arr_drain.md
Name: pe_arr_drain

Overview:
- Consumer end of the PE_ARR result interface: watches the array's per-PE `outs`/`outvalids`, snapshots a completed tile and requantizes each 32-bit accumulator to signed 8-bit.
- Streams the tile out row by row over a valid/ready interface toward the activation buffer.
- Sits directly downstream of PE_ARR, the counterpart of the stimulus side that drives `in_w`/`in_a`/`fire`.

Parameters:
- ROWS, 8, PE array rows; must match PE_ARR `rows`.
- COLS, 8, PE array columns; must match PE_ARR `cols`.
- ACC_W, 32, accumulator width of each PE output.
- Q_W, 8, requantized output element width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- outs  in  ACC_W x [0:ROWS*COLS-1] (unpacked)  PE accumulators, row-major, index r*COLS+c.
- outvalids  in  1 x [0:ROWS*COLS-1] (unpacked)  per-PE valid.
- shift  in  5  right-shift amount for requantization, sampled at capture.
- clr_ovr  in  1  clears the sticky overrun flag.
- out_valid  out  1  row beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  COLS*Q_W  row data; element c occupies bits [c*Q_W +: Q_W].
- out_row  out  $clog2(ROWS)  row index of the current beat.
- out_last  out  1  high with the final row beat (row ROWS-1).
- busy  out  1  high while not in IDLE.
- overrun  out  1  sticky: a new tile arrived while draining.

Behaviour:
- Reset (rstn=0 at posedge):
  - state=IDLE; row counter=0; all_v_q=0; overrun=0; buffer contents don't-care.
  - out_valid=0, out_data=0, out_row=0, out_last=0, busy=0.
- all_v = AND of all outvalids[]. all_v_q is all_v registered every cycle. tile_evt = all_v & ~all_v_q (rising edge), so a held-valid tile captures only once.
- State IDLE:
  - On tile_evt: for every element, store q(outs[i]) into the ROWS x COLS x Q_W buffer; latch shift.
  - Next state SEND, row counter=0.
- Requantization q(x), with x a signed ACC_W value:
  - shift=0: y=x.
  - shift>0: y = (x + (1<<(shift-1))) >>> shift, round half up, computed at ACC_W+1 bits so it cannot overflow.
  - Saturate y to [-128,127].
- State SEND:
  - out_valid=1; out_data = buffer row[row counter]; out_row = row counter; out_last = (row counter == ROWS-1).
  - Outputs are combinational from registers and stay stable while out_ready=0.
  - Handshake is out_valid & out_ready: increment row counter. If out_last, go to IDLE (out_valid=0 next cycle).
  - Throughput: 1 row per cycle with ready held high; tile drain = ROWS cycles.
  - Latency: tile_evt cycle N → first beat out_valid=1 in cycle N+1.
- Overrun:
  - tile_evt while in SEND: tile dropped, buffer untouched, overrun←1.
  - tile_evt in the same cycle as the final handshake is also dropped and sets overrun; no back-to-back capture.
  - overrun clears only on clr_ovr=1 or reset. If clr_ovr and a new overrun event coincide, overrun stays set.
- busy = (state != IDLE).
- Reset mid-SEND: next cycle out_valid=0, IDLE, the partial tile is discarded, overrun=0.

Decomposition:
- Shared package pe_arr_pkg holds:
  - ACC_W and Q_W defaults.
  - The state enum drain_state_t {IDLE, SEND}.
  - Q_MAX=127 and Q_MIN=-128 constants.
- One sub-module, pe_requant: purely combinational; signed ACC_W in, shift in, Q_W saturated out. Instantiated ROWS*COLS times via generate.

Test Plan:
- Basic drain (8x8): all outs=10, all outvalids rise together, shift=0, out_ready=1 → 8 consecutive beats, each out_data=0x0A0A0A0A0A0A0A0A; out_row 0..7; out_last only on row 7; busy drops the cycle after.
- Rounding: outs[0]=6, outs[1]=5, outs[2]=-6, shift=2 → row 0 bytes 2, 1, -1 (0xFF).
- Saturation: outs[0]=1000, outs[1]=-1000, outs[2]=0x7FFFFFFF with shift=0 → 0x7F, 0x80, 0x7F.
- Backpressure: drop out_ready for 3 cycles during row 3 → out_row=3 and out_data held stable; no row skipped or duplicated; total 8 handshakes.
- Held valid vs overrun:
  - outvalids held high 20 cycles → exactly one tile drained.
  - outvalids pulsed low/high during row 2 → overrun=1, drained data unchanged; clr_ovr → overrun=0.
- Mid-drain reset: rstn=0 at row 4 → next cycle out_valid=0, busy=0; a fresh tile then drains from row 0.
